sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 18 +
 rtl/sram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and constants for the asynchronous SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

    localparam int         DEF_READ_WAIT  = 1;
    localparam int         DEF_WRITE_WAIT = 1;
    localparam int         CNT_W          = 16;
    localparam logic [3:0] BE_FULL        = 4'b1111;
    localparam logic [3:0] BE_NONE        = 4'b0000;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one outstanding request, full writes,
// read-modify-write for partial byte enables, and registered SRAM strobes.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [19:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [19:0] sram_addr,
    inout  wire  [31:0] sram_data,
    output logic        sram_ce,
    output logic        sram_oe,
    output logic        sram_we
);

    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [19:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              ce_q, oe_q, we_q, drive_q, ready_q;

    // Keep the enabled bytes of the new data and the rest of the word read from SRAM.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Next-state, request capture, and the shared READ/WR_PULSE wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (wr && (be == BE_NONE)) begin
                        ack_d = 1'b1;
                    end else if (wr && (be == BE_FULL)) begin
                        state_d = ST_WR_SETUP;
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = RD_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q == CNT_ZERO) begin
                    if (wr_q) begin
                        wdata_d = merge_bytes(sram_data, wdata_q, be_q);
                        state_d = ST_WR_SETUP;
                    end else begin
                        rdata_d = sram_data;
                        ack_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WR_HOLD: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and strobes; strobes are decoded from the next state so they are glitch-free flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            addr_q  <= 20'h0_0000;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'b0000;
            rdata_q <= 32'h0000_0000;
            ack_q   <= 1'b0;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drive_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ce_q    <= (state_d == ST_IDLE);
            oe_q    <= (state_d != ST_READ);
            we_q    <= (state_d != ST_WR_PULSE);
            drive_q <= (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                       (state_d == ST_WR_HOLD);
            ready_q <= (state_d == ST_IDLE);
        end
    end

    assign sram_data = drive_q ? wdata_q : {32{1'bz}};
    assign sram_addr = addr_q;
    assign sram_ce   = ce_q;
    assign sram_oe   = oe_q;
    assign sram_we   = we_q;
    assign ready     = ready_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: two instances (default waits and READ_WAIT=3/WRITE_WAIT=2),
// each with its own SRAM responder, directed scenarios and randomized traffic.
module tb_sram_ctrl;

    typedef struct {
        bit          is_read;
        logic [19:0] addr;
        logic [31:0] data;
        logic [31:0] wword;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        check32(name, {31'h0, got}, {31'h0, exp});
    endtask

    task automatic fail_now(input string name);
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL %s: expected event did not occur in time", name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int RW = (g == 0) ? 1 : 3;
        localparam int WW = (g == 0) ? 1 : 2;

        logic        rst_n, req, wr, ready, ack, wipe, fin;
        logic [19:0] addr, sram_addr;
        logic [31:0] wdata, rdata, last_rdata;
        logic [3:0]  be;
        logic        sram_ce, sram_oe, sram_we;
        wire  [31:0] sram_data;
        logic [31:0] mem [256];
        logic [31:0] ref_mem [256];
        exp_t        sb [$];
        int          ce_cnt;
        int          we_len;

        sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
            .clk       (clk),
            .rst       (rst_n),
            .req       (req),
            .wr        (wr),
            .addr      (addr),
            .wdata     (wdata),
            .be        (be),
            .ready     (ready),
            .ack       (ack),
            .rdata     (rdata),
            .sram_addr (sram_addr),
            .sram_data (sram_data),
            .sram_ce   (sram_ce),
            .sram_oe   (sram_oe),
            .sram_we   (sram_we)
        );

        // SRAM responder: drives the bus while selected with oe low, stores while we is low.
        assign sram_data = (!sram_ce && !sram_oe) ? mem[sram_addr[7:0]] : {32{1'bz}};

        always @(posedge clk) begin
            if (wipe) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            end else if (!sram_ce && !sram_we) begin
                mem[sram_addr[7:0]] <= sram_data;
            end
        end

        // Monitor: bus protocol per cycle, and scoreboard pop on every ack.
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                sb.delete();
                ce_cnt = 0;
                we_len = 0;
                last_rdata = 32'h0;
            end else begin
                if (!sram_ce) begin
                    ce_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL idle_bus: sram_ce=0, required 1 with no transaction pending");
                    end else begin
                        check32("addr_stable", {12'h0, sram_addr}, {12'h0, sb[0].addr});
                        if (!sram_oe) check32("bus_contention", sram_data, mem[sram_addr[7:0]]);
                        else if (sb[0].is_read) check1("rd_oe_low", sram_oe, 1'b0);
                        else check32("wr_bus_word", sram_data, sb[0].wword);
                    end
                end
                if (!sram_we) begin
                    we_len++;
                end else if (we_len != 0) begin
                    check32("we_pulse_len", 32'(we_len), 32'(WW));
                    we_len = 0;
                end
                if (ack) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_ack: ack=1, required 0 with nothing outstanding");
                    end else begin
                        e = sb.pop_front();
                        check32("ack_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                        check32("active_cycles", 32'(ce_cnt), 32'(e.lat - 1));
                        if (e.is_read) begin
                            check32("rdata", rdata, e.data);
                            last_rdata = e.data;
                        end
                    end
                    ce_cnt = 0;
                end else begin
                    check32("rdata_hold", rdata, last_rdata);
                end
            end
        end

        // Present one request at a negedge, wait for ready, push the expectation, then scramble inputs.
        task automatic issue(input logic w, input logic [19:0] a, input logic [31:0] d,
                             input logic [3:0] b, output logic ack_seen);
            exp_t        e;
            logic [31:0] mask;
            logic [31:0] r;
            int          n;
            req = 1'b1; wr = w; addr = a; wdata = d; be = b;
            n = 0;
            while (!ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            ack_seen = ack;
            if (!ready) begin
                fail_now("accept");
                req = 1'b0;
            end else begin
                mask      = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                e.is_read = !w;
                e.addr    = a;
                e.data    = ref_mem[a[7:0]];
                e.wword   = (ref_mem[a[7:0]] & ~mask) | (d & mask);
                e.acc     = cyc + 1;
                if (!w)                e.lat = RW + 1;
                else if (b == 4'hF)    e.lat = WW + 3;
                else if (b == 4'h0)    e.lat = 1;
                else                   e.lat = RW + WW + 3;
                if (w) ref_mem[a[7:0]] = e.wword;
                sb.push_back(e);
                @(posedge clk);
                #1;
                r = $urandom;
                req = 1'b0; wr = r[0]; addr = r[31:12]; wdata = $urandom; be = r[7:4];
                @(negedge clk);
            end
        endtask

        task automatic wait_ack_rd(input string name, input logic [31:0] exp);
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!ack && n < 200);
            if (!ack) fail_now(name);
            else check32(name, rdata, exp);
        endtask

        // Stimulus: reset state, directed scenarios, reset mid-write, random traffic.
        initial begin
            logic        a_s;
            logic [31:0] r;
            logic [19:0] a;
            logic [3:0]  b;
            int          n;
            rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = 20'h0; wdata = 32'h0; be = 4'h0;
            wipe = 1'b1; fin = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
            repeat (3) @(negedge clk);
            wipe = 1'b0;
            check1("reset_ready", ready, 1'b1);
            check1("reset_ack", ack, 1'b0);
            check1("reset_ce", sram_ce, 1'b1);
            check1("reset_oe", sram_oe, 1'b1);
            check1("reset_we", sram_we, 1'b1);
            check32("reset_addr", {12'h0, sram_addr}, 32'h0);
            check32("reset_rdata", rdata, 32'h0);
            #2 rst_n = 1'b1;
            @(negedge clk);

            issue(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, a_s);
            issue(1'b0, 20'h00010, 32'h0, 4'h0, a_s);
            check32("model_word", mem[8'h10], 32'hDEADBEEF);
            wait_ack_rd("spec_read", 32'hDEADBEEF);
            issue(1'b1, 20'h00010, 32'h11223344, 4'b0101, a_s);
            issue(1'b0, 20'h00010, 32'h0, 4'h0, a_s);
            wait_ack_rd("spec_merge", 32'hDE22BE44);
            issue(1'b1, 20'h00001, 32'hA5A5A5A5, 4'hF, a_s);
            issue(1'b0, 20'h00001, 32'h0, 4'h0, a_s);
            check1("b2b_no_gap", a_s, 1'b1);
            wait_ack_rd("b2b_read", 32'hA5A5A5A5);

            issue(1'b1, 20'h000FF, 32'h0BADF00D, 4'hF, a_s);
            n = 0;
            while (sram_we && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (sram_we) fail_now("reach_wr_pulse");
            #2 rst_n = 1'b0;
            #1;
            check1("rst_mid_we", sram_we, 1'b1);
            check1("rst_mid_ce", sram_ce, 1'b1);
            check1("rst_mid_oe", sram_oe, 1'b1);
            check1("rst_mid_ready", ready, 1'b1);
            check1("rst_mid_ack", ack, 1'b0);
            check32("rst_mid_addr", {12'h0, sram_addr}, 32'h0);
            check32("rst_mid_rdata", rdata, 32'h0);
            @(negedge clk);
            #2 rst_n = 1'b1;
            @(negedge clk);
            issue(1'b0, 20'h00001, 32'h0, 4'h0, a_s);
            wait_ack_rd("post_rst_read", 32'hA5A5A5A5);

            for (int t = 0; t < 60; t++) begin
                r = $urandom;
                a = {r[31:20], 8'(r[7:0] % 8'd255)};
                case (r[9:8])
                    2'd0:    b = 4'hF;
                    2'd1:    b = 4'h0;
                    default: b = r[13:10];
                endcase
                issue(r[15], a, $urandom, b, a_s);
                if (r[17:16] == 2'd0) repeat (2) @(negedge clk);
            end

            n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) fail_now("drain");
            repeat (2) @(negedge clk);
            fin = 1'b1;
        end
    end

    // Wait for both instances to finish (bounded), then report.
    initial begin
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            if (h[0].fin && h[1].fin) break;
        end
        if (!(h[0].fin && h[1].fin)) fail_now("run_complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
